sdram_burst_responder: RTL and testbench

- Responder (memory side) of the 24-bit-address / 16-bit-word SDRAM request/ack interface driven by the line cache.
- Serves 8-word read bursts and single-word writes from an internal word array with programmable latency.
- Acts as the SDRAM stand-in for cache and CPU/WOPI system benches, and as the protocol-compliance target.

---
 rtl/sdram_burst_responder.sv | 148 ++++++++++++++
 tb/tb_sdram_burst_responder.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_responder.sv
// Memory-side responder for the 24-bit-address / 16-bit-word SDRAM request/ack interface.
// Serves 8-word wrapping read bursts and single-word writes from an internal array with programmable latency.
module sdram_burst_responder #(
    parameter int ADDR_BITS     = 12,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 2,
    parameter int BURST_LEN     = 8
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic [23:0] address,
    input  logic [15:0] data_write,
    input  logic        read_req,
    input  logic        write_req,
    output logic [15:0] data_read,
    output logic        read_ack,
    output logic        write_ack,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_WAIT,
        WR_HOLD
    } state_t;

    localparam logic [3:0] RD_LAT     = 4'(READ_LATENCY);
    localparam logic [3:0] WR_LAT     = 4'(WRITE_LATENCY);
    localparam logic [3:0] WR_COMMIT  = 4'(WRITE_LATENCY - 1);
    localparam logic [2:0] LAST_BEAT  = 3'(BURST_LEN - 1);
    localparam int         MEM_WORDS  = 1 << ADDR_BITS;

    logic [15:0]          mem [0:MEM_WORDS-1];

    state_t               state;
    logic [3:0]           lat_cnt;
    logic [2:0]           beat;
    logic [ADDR_BITS-1:0] addr_q;
    logic [15:0]          wdata_q;

    logic [2:0]           rd_off;
    logic [ADDR_BITS-1:0] rd_idx;
    logic                 accept_wr;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [15:0]          mem_wdata;

    // Address bits above the backed storage alias onto the array.
    logic                 unused_addr_hi;
    assign unused_addr_hi = ^address[23:ADDR_BITS];

    // Critical word first: the beat offset wraps inside the aligned 8-word line.
    assign rd_off    = addr_q[2:0] + beat;
    assign rd_idx    = {addr_q[ADDR_BITS-1:3], rd_off};
    assign accept_wr = (state == IDLE) && !read_req && write_req;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
        if (reset_n) begin
            // With a one-cycle write latency the commit coincides with acceptance.
            if (accept_wr && (WRITE_LATENCY == 1)) begin
                mem_we    = 1'b1;
                mem_waddr = address[ADDR_BITS-1:0];
                mem_wdata = data_write;
            end else if ((state == WR_WAIT) && (lat_cnt == WR_COMMIT)) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            read_ack  <= 1'b0;
            write_ack <= 1'b0;
            busy      <= 1'b0;
            data_read <= 16'h0000;
            lat_cnt   <= 4'd0;
            beat      <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= 16'h0000;
        end else begin
            read_ack  <= 1'b0;
            write_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_req) begin
                        addr_q  <= address[ADDR_BITS-1:0];
                        lat_cnt <= 4'd1;
                        state   <= RD_WAIT;
                        busy    <= 1'b1;
                    end else if (write_req) begin
                        addr_q  <= address[ADDR_BITS-1:0];
                        wdata_q <= data_write;
                        lat_cnt <= 4'd1;
                        state   <= WR_WAIT;
                        busy    <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == RD_LAT) begin
                        read_ack <= 1'b1;
                        beat     <= 3'd0;
                        state    <= RD_BURST;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                RD_BURST: begin
                    data_read <= mem[rd_idx];
                    beat      <= beat + 3'd1;
                    if (beat == LAST_BEAT) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                WR_WAIT: begin
                    if (lat_cnt == WR_LAT) begin
                        write_ack <= 1'b1;
                        state     <= WR_HOLD;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                WR_HOLD: begin
                    // Inputs ignored for one cycle so the requester can advance after the ack.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Directed bench for sdram_burst_responder: latency, burst order, write stream, collision, reset abort, aliasing.
module tb_sdram_burst_responder;

    localparam int RL = 3;
    localparam int WL = 2;
    localparam int AB = 12;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic [23:0] address;
    logic [15:0] data_write;
    logic        read_req;
    logic        write_req;
    logic [15:0] data_read;
    logic        read_ack;
    logic        write_ack;
    logic        busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 sys_clk = ~sys_clk;

    sdram_burst_responder #(
        .ADDR_BITS    (AB),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL),
        .BURST_LEN    (8)
    ) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .address   (address),
        .data_write(data_write),
        .read_req  (read_req),
        .write_req (write_req),
        .data_read (data_read),
        .read_ack  (read_ack),
        .write_ack (write_ack),
        .busy      (busy)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Single write; ack_at is the edge count from acceptance (edge A = 0) to write_ack.
    task automatic do_write(input logic [23:0] a, input logic [15:0] d, output int ack_at);
        ack_at     = -1;
        address    = a;
        data_write = d;
        write_req  = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            if (write_ack) begin
                ack_at = n;
                break;
            end
        end
        write_req = 1'b0;
        step();
        step();
    endtask

    // Read burst; read_req dropped right after acceptance. Words captured on the 8 cycles after read_ack.
    task automatic do_read(input logic [23:0] a, output int ack_at, output int ack_total,
                           output logic [127:0] words, output logic busy_mid, output logic busy_end);
        ack_at    = -1;
        ack_total = 0;
        words     = '0;
        busy_mid  = 1'b0;
        busy_end  = 1'b1;
        address   = a;
        read_req  = 1'b1;
        for (int n = 0; n < 40 && ack_at < 0; n++) begin
            step();
            if (n == 0) read_req = 1'b0;
            if (read_ack) begin
                ack_at = n;
                ack_total++;
            end
        end
        read_req = 1'b0;
        if (ack_at >= 0) begin
            for (int k = 0; k < 8; k++) begin
                step();
                if (read_ack) ack_total++;
                words[16*k +: 16] = data_read;
                if (k == 6) busy_mid = busy;
                if (k == 7) busy_end = busy;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        step();
        vec_cnt++;
        if (read_ack !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_read_ack: got %0b exp 0", read_ack);
        end
        vec_cnt++;
        if (write_ack !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_write_ack: got %0b exp 0", write_ack);
        end
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_busy: got %0b exp 0", busy);
        end
        vec_cnt++;
        if (data_read !== 16'h0000) begin
            err_cnt++;
            $display("FAIL reset_data_read: got %h exp 0000", data_read);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_read_burst();
        int ack_at, ack_total;
        logic [127:0] w;
        logic bm, be;
        for (int i = 0; i < 8; i++) begin
            do_write(24'(32'h10 + i), 16'(32'hA000 + i), ack_at);
            vec_cnt++;
            if (ack_at != WL) begin
                err_cnt++;
                $display("FAIL preload_ack_latency[%0d]: got %0d exp %0d", i, ack_at, WL);
            end
        end
        do_read(24'h000010, ack_at, ack_total, w, bm, be);
        vec_cnt++;
        if (ack_at != RL) begin
            err_cnt++;
            $display("FAIL read_ack_latency: got %0d exp %0d", ack_at, RL);
        end
        vec_cnt++;
        if (ack_total != 1) begin
            err_cnt++;
            $display("FAIL read_ack_count: got %0d exp 1", ack_total);
        end
        for (int k = 0; k < 8; k++) begin
            vec_cnt++;
            if (w[16*k +: 16] !== 16'(32'hA000 + k)) begin
                err_cnt++;
                $display("FAIL read_word[%0d]: got %h exp %h", k, w[16*k +: 16], 16'(32'hA000 + k));
            end
        end
        vec_cnt++;
        if (bm !== 1'b1) begin
            err_cnt++;
            $display("FAIL read_busy_mid: got %0b exp 1", bm);
        end
        vec_cnt++;
        if (be !== 1'b0) begin
            err_cnt++;
            $display("FAIL read_busy_end: got %0b exp 0", be);
        end
    endtask

    task automatic test_write_stream();
        int acks[8];
        int i;
        int ack_at, ack_total;
        logic [127:0] w;
        logic bm, be;
        i = 0;
        address    = 24'h000020;
        data_write = 16'h1234;
        write_req  = 1'b1;
        for (int n = 0; n < 100 && i < 8; n++) begin
            step();
            if (write_ack) begin
                acks[i] = n;
                i++;
                if (i < 8) begin
                    address    = 24'(32'h20 + i);
                    data_write = 16'(32'h1234 + i);
                end else begin
                    write_req = 1'b0;
                end
            end
        end
        write_req = 1'b0;
        step();
        step();
        vec_cnt++;
        if (i != 8) begin
            err_cnt++;
            $display("FAIL stream_ack_count: got %0d exp 8", i);
        end
        vec_cnt++;
        if (acks[0] != WL) begin
            err_cnt++;
            $display("FAIL stream_first_ack: got %0d exp %0d", acks[0], WL);
        end
        for (int k = 1; k < 8 && k < i; k++) begin
            vec_cnt++;
            if (acks[k] - acks[k-1] != WL + 2) begin
                err_cnt++;
                $display("FAIL stream_ack_gap[%0d]: got %0d exp %0d", k, acks[k] - acks[k-1], WL + 2);
            end
        end
        do_read(24'h000020, ack_at, ack_total, w, bm, be);
        for (int k = 0; k < 8; k++) begin
            vec_cnt++;
            if (w[16*k +: 16] !== 16'(32'h1234 + k)) begin
                err_cnt++;
                $display("FAIL stream_readback[%0d]: got %h exp %h", k, w[16*k +: 16], 16'(32'h1234 + k));
            end
        end
    endtask

    task automatic test_unaligned();
        int ack_at, ack_total;
        logic [127:0] w;
        logic bm, be;
        for (int i = 0; i < 8; i++) begin
            do_write(24'(32'h30 + i), 16'(32'hB0 + i), ack_at);
        end
        do_read(24'h000035, ack_at, ack_total, w, bm, be);
        vec_cnt++;
        if (ack_at != RL) begin
            err_cnt++;
            $display("FAIL unaligned_ack_latency: got %0d exp %0d", ack_at, RL);
        end
        for (int k = 0; k < 8; k++) begin
            vec_cnt++;
            if (w[16*k +: 16] !== 16'(32'hB0 + ((5 + k) % 8))) begin
                err_cnt++;
                $display("FAIL unaligned_word[%0d]: got %h exp %h", k, w[16*k +: 16], 16'(32'hB0 + ((5 + k) % 8)));
            end
        end
    endtask

    task automatic test_read_write_collision();
        int ack_at, ack_total;
        int rd_at, wr_at, rd_n, wr_n, overlap;
        logic [15:0] w0;
        logic [127:0] w;
        logic bm, be;
        do_write(24'h000040, 16'h1111, ack_at);
        rd_at = -1; wr_at = -1; rd_n = 0; wr_n = 0; overlap = 0; w0 = 16'h0000;
        address    = 24'h000040;
        data_write = 16'hC0DE;
        read_req   = 1'b1;
        write_req  = 1'b1;
        for (int n = 0; n < 25; n++) begin
            step();
            if (n == 0) read_req = 1'b0;
            if (read_ack && write_ack) overlap++;
            if (read_ack) begin
                rd_n++;
                rd_at = n;
            end
            if (write_ack) begin
                wr_n++;
                wr_at = n;
                write_req = 1'b0;
            end
            if (n == RL + 1) w0 = data_read;
        end
        write_req = 1'b0;
        vec_cnt++;
        if (rd_at != RL || rd_n != 1) begin
            err_cnt++;
            $display("FAIL collision_read_ack: got at %0d count %0d exp at %0d count 1", rd_at, rd_n, RL);
        end
        vec_cnt++;
        if (w0 !== 16'h1111) begin
            err_cnt++;
            $display("FAIL collision_read_old_data: got %h exp 1111", w0);
        end
        vec_cnt++;
        if (wr_at != RL + 9 + WL || wr_n != 1) begin
            err_cnt++;
            $display("FAIL collision_write_ack: got at %0d count %0d exp at %0d count 1", wr_at, wr_n, RL + 9 + WL);
        end
        vec_cnt++;
        if (overlap != 0) begin
            err_cnt++;
            $display("FAIL collision_ack_overlap: got %0d exp 0", overlap);
        end
        do_read(24'h000040, ack_at, ack_total, w, bm, be);
        vec_cnt++;
        if (w[15:0] !== 16'hC0DE) begin
            err_cnt++;
            $display("FAIL collision_write_readback: got %h exp c0de", w[15:0]);
        end
    endtask

    task automatic test_reset_mid_read();
        int ack_at, ack_total, late_acks;
        logic [127:0] w;
        logic bm, be;
        do_read(24'h000010, ack_at, ack_total, w, bm, be);
        address  = 24'h000010;
        read_req = 1'b1;
        step();
        read_req = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        vec_cnt++;
        if (read_ack !== 1'b0 || write_ack !== 1'b0) begin
            err_cnt++;
            $display("FAIL midreset_acks: got rd %0b wr %0b exp 0 0", read_ack, write_ack);
        end
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL midreset_busy: got %0b exp 0", busy);
        end
        vec_cnt++;
        if (data_read !== 16'h0000) begin
            err_cnt++;
            $display("FAIL midreset_data_read: got %h exp 0000", data_read);
        end
        reset_n = 1'b1;
        late_acks = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (read_ack || write_ack || busy) late_acks++;
        end
        vec_cnt++;
        if (late_acks != 0) begin
            err_cnt++;
            $display("FAIL midreset_no_resume: got %0d active cycles exp 0", late_acks);
        end
        do_read(24'h000010, ack_at, ack_total, w, bm, be);
        vec_cnt++;
        if (ack_at != RL) begin
            err_cnt++;
            $display("FAIL midreset_reread_latency: got %0d exp %0d", ack_at, RL);
        end
        for (int k = 0; k < 8; k++) begin
            vec_cnt++;
            if (w[16*k +: 16] !== 16'(32'hA000 + k)) begin
                err_cnt++;
                $display("FAIL midreset_reread[%0d]: got %h exp %h", k, w[16*k +: 16], 16'(32'hA000 + k));
            end
        end
    endtask

    task automatic test_alias();
        int ack_at, ack_total;
        logic [127:0] w;
        logic bm, be;
        do_write(24'h001005, 16'h5A5A, ack_at);
        do_read(24'h000000, ack_at, ack_total, w, bm, be);
        vec_cnt++;
        if (ack_at != RL) begin
            err_cnt++;
            $display("FAIL alias_read_latency: got %0d exp %0d", ack_at, RL);
        end
        vec_cnt++;
        if (w[16*5 +: 16] !== 16'h5A5A) begin
            err_cnt++;
            $display("FAIL alias_word5: got %h exp 5a5a", w[16*5 +: 16]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        read_req   = 1'b0;
        write_req  = 1'b0;
        address    = 24'h000000;
        data_write = 16'h0000;
        test_reset();
        test_read_burst();
        test_write_stream();
        test_unaligned();
        test_read_write_collision();
        test_reset_mid_read();
        test_alias();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
